lfsr_multi_screen_gen: RTL
==========================

// Module: lfsr_multi_screen_gen
// PURPOSE
//  Parametrised puzzle-screen generator for the bomb-defuse game. It generalises the four-screen LFSR
//  generator to N screens of SYM_W-bit symbols, with an optional all-distinct mode.
//  A free-running Galois LFSR draws one symbol per screen on each button press, then picks a "main"
//  symbol from one of the screens. The new set is published atomically with a one-cycle screen_done.
//  Sits between the debounced button input and the screen display/compare logic.
// PARAMETERS
//  N_SCREENS  4        number of screens, 2..16
//  SYM_W      2        bits per screen symbol
//  LFSR_W     16       LFSR state width
//  TAPS       16'hB400 Galois feedback mask, LFSR_W bits
//  SEED       16'hACE1 reset value of LFSR; a value of 0 is replaced by 1
//  UNIQUE     0        1 = all screen symbols distinct; requires N_SCREENS <= 2**SYM_W
//  RETRY_MAX  8        max redraws per slot before the deterministic fallback
// PORTS
//  clk          in   1                  system clock, rising edge
//  rst          in   1                  asynchronous, active-low reset
//  button       in   1                  asynchronous pushbutton level; synchronised internally
//  screens      out  N_SCREENS*SYM_W    screen i = screens[i*SYM_W +: SYM_W]
//  main         out  SYM_W              main-screen symbol, always equal to screen main_idx
//  main_idx     out  clog2(N_SCREENS)   index of the screen whose symbol is main
//  busy         out  1                  high while a generation is in progress
//  screen_done  out  1                  one-cycle pulse when new outputs become valid
// BEHAVIOUR
//  Reset (rst=0, async): LFSR=SEED (1 if SEED=0); FSM=IDLE; screens=0, main=0, main_idx=0, busy=0,
//   screen_done=0; sync flops=0; shadow registers=0.
//  LFSR: steps every clk, in every state: s <= s[0] ? (s>>1)^TAPS : s>>1. Press timing provides entropy.
//   If s==0 is ever seen, reload SEED (or 1). A draw uses s[SYM_W-1:0] of the current cycle.
//  Button: 2-flop synchroniser, then rising-edge detect; press = sync_q & ~sync_q_d.
//   A press is accepted only in IDLE. Presses while busy are dropped, not queued.
//  FSM:
//   IDLE: on press -> GEN; slot=0, busy=1.
//   GEN: one draw per cycle into shadow[slot].
//    UNIQUE=0: always accept the draw and advance slot.
//    UNIQUE=1: reject a draw equal to any shadow[0..slot-1] and retry next cycle. After RETRY_MAX
//     rejects, store the smallest unused symbol. After slot N_SCREENS-1 is accepted -> PICK.
//   PICK: idx = s[IDX_W-1:0]. Accept if idx < N_SCREENS, else retry.
//    After RETRY_MAX rejects, idx = 0. On accept -> DONE.
//   DONE (1 cycle): copy shadow to screens, main=shadow[idx], main_idx=idx; screen_done=1, busy=0;
//    next state IDLE.
//  Outputs change only in the DONE cycle, so displays never show a partial set.
//  Latency: press detected at edge k -> screen_done high at edge k+N_SCREENS+2 when no retries occur.
//   Each retry adds 1 cycle. Upper bound: N_SCREENS*(RETRY_MAX+1)+RETRY_MAX+2 cycles.
//  A press in the DONE cycle is ignored. A press in the cycle after DONE starts a new run.
//  Async reset mid-GEN/PICK/DONE aborts the run: no screen_done, all outputs at reset values.
//  main always equals the screen at main_idx. main_idx < N_SCREENS always.
// TESTING
//  1 Reset: hold rst=0 for 3 clks -> screens=0, main=0, main_idx=0, busy=0, screen_done=0.
//    After release, with no press, outputs stay 0.
//  2 Defaults: button 0->1 held 5 clks -> exactly one screen_done pulse, N_SCREENS+2 clks after edge
//    detect. screens and main match a bench LFSR model seeded 16'hACE1 and stepping every clk.
//    main == screen[main_idx].
//  3 UNIQUE=1, N_SCREENS=4, SYM_W=2: 50 presses at varied spacing -> every screens value is a
//    permutation of {0,1,2,3}. main_idx in 0..3 on every run.
//  4 Busy drop: N_SCREENS=8, second press 2 clks after the first -> one screen_done only.
//    busy high from accept until DONE.
//  5 Abort: rst=0 pulsed during GEN (slot 2) -> outputs 0 immediately, no screen_done.
//    The next press yields a full new set.
//  6 SEED=0, N_SCREENS=3: run 20 presses -> LFSR never stuck at 0 (model starts from 1),
//    main_idx never equals 3, fallback path exercised.

Source files
------------

// File: rtl/lfsr_multi_screen_gen.sv
// Puzzle-screen generator: a free-running Galois LFSR fills N_SCREENS symbols on each accepted press,
// then picks a main screen. The new set is published atomically, with a one-cycle screen_done.
module lfsr_multi_screen_gen #(
   parameter int                N_SCREENS = 4,
   parameter int                SYM_W     = 2,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                UNIQUE    = 0,
   parameter int                RETRY_MAX = 8,
   localparam int               IDX_W     = $clog2(N_SCREENS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       button,
   output logic [N_SCREENS*SYM_W-1:0] screens,
   output logic [SYM_W-1:0]           main,
   output logic [IDX_W-1:0]           main_idx,
   output logic                       busy,
   output logic                       screen_done
);

   localparam int                RTY_W     = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam int                N_SYMS    = 1 << SYM_W;
   localparam int                IDX_W1    = IDX_W + 1;
   localparam logic [LFSR_W-1:0] SEED_NZ   = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(N_SCREENS - 1);
   localparam logic [RTY_W-1:0]  RTY_LIM   = RTY_W'(RETRY_MAX);
   localparam logic [IDX_W:0]    N_LIM     = IDX_W1'(N_SCREENS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_PICK = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
   logic                       sync1_q, sync_q, sync_dly_q;
   logic [IDX_W-1:0]           slot_q, slot_d;
   logic [RTY_W-1:0]           rty_q, rty_d;
   logic [SYM_W-1:0]           shadow_q [N_SCREENS];
   logic [SYM_W-1:0]           shadow_d [N_SCREENS];
   logic [N_SCREENS*SYM_W-1:0] screens_q, screens_d;
   logic [SYM_W-1:0]           main_q, main_d;
   logic [IDX_W-1:0]           main_idx_q, main_idx_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic                       press_s;
   logic [SYM_W-1:0]           draw_s;
   logic [SYM_W-1:0]           free_s;
   logic [N_SYMS-1:0]          used_s;
   logic                       dup_s;
   logic [IDX_W-1:0]           pick_s;
   logic                       pick_ok_s;
   logic [IDX_W-1:0]           pick_sel_s;

   assign press_s    = sync_q & ~sync_dly_q;
   assign draw_s     = lfsr_q[SYM_W-1:0];
   assign pick_s     = lfsr_q[IDX_W-1:0];
   assign pick_ok_s  = ({1'b0, pick_s} < N_LIM);
   assign pick_sel_s = pick_ok_s ? pick_s : '0;

   // LFSR next state; an all-zero state can never advance, so it reloads the seed
   always_comb begin
      if (lfsr_q == '0) begin
         lfsr_d = SEED_NZ;
      end else if (lfsr_q[0]) begin
         lfsr_d = (lfsr_q >> 1) ^ TAPS;
      end else begin
         lfsr_d = lfsr_q >> 1;
      end
   end

   // Symbols already placed this run, duplicate flag and smallest free symbol
   always_comb begin
      used_s = '0;
      for (int i = 0; i < N_SCREENS; i++) begin
         used_s = used_s | ((IDX_W'(i) < slot_q) ? (N_SYMS'(1) << shadow_q[i]) : '0);
      end
      dup_s  = used_s[draw_s];
      free_s = '0;
      for (int k = N_SYMS - 1; k >= 0; k--) begin
         free_s = used_s[k] ? free_s : SYM_W'(k);
      end
   end

   // Generation FSM: next state, shadow fill and publish of the finished set
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      rty_d      = rty_q;
      shadow_d   = shadow_q;
      screens_d  = screens_q;
      main_d     = main_q;
      main_idx_d = main_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press_s) begin
               state_d = S_GEN;
               slot_d  = '0;
               rty_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GEN: begin
            if ((UNIQUE == 0) || !dup_s || (rty_q == RTY_LIM)) begin
               shadow_d[slot_q] = ((UNIQUE != 0) && dup_s) ? free_s : draw_s;
               rty_d            = '0;
               if (slot_q == LAST_SLOT) begin
                  state_d = S_PICK;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end else begin
               rty_d = rty_q + 1'b1;
            end
         end
         S_PICK: begin
            if (pick_ok_s || (rty_q == RTY_LIM)) begin
               for (int i = 0; i < N_SCREENS; i++) begin
                  screens_d[i*SYM_W +: SYM_W] = shadow_q[i];
               end
               main_d     = shadow_q[pick_sel_s];
               main_idx_d = pick_sel_s;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               rty_d      = '0;
               state_d    = S_DONE;
            end else begin
               rty_d = rty_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Free-running LFSR and button synchroniser with edge-detect delay flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q     <= SEED_NZ;
         sync1_q    <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         lfsr_q     <= lfsr_d;
         sync1_q    <= button;
         sync_q     <= sync1_q;
         sync_dly_q <= sync_q;
      end
   end

   // FSM state, shadow set and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         slot_q     <= '0;
         rty_q      <= '0;
         screens_q  <= '0;
         main_q     <= '0;
         main_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < N_SCREENS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         rty_q      <= rty_d;
         screens_q  <= screens_d;
         main_q     <= main_d;
         main_idx_q <= main_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         for (int i = 0; i < N_SCREENS; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign screens     = screens_q;
   assign main        = main_q;
   assign main_idx    = main_idx_q;
   assign busy        = busy_q;
   assign screen_done = done_q;

endmodule
